fib_seq: RTL and testbench
==========================

FIB_SEQ -- requirements
Module: fib_seq

Interface
REQ-001 SHALL have parameter N, default 16: data width of in0/out0 and of the iteration counter.
REQ-002 SHALL have parameter SAT, default 0: 0 = out0 wraps modulo 2^N; 1 = out0 saturates to all-ones on overflow.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: request present on in0.
REQ-006 SHALL have port in_ready  output  1: block can accept a request this cycle.
REQ-007 SHALL have port in0  input  N: index n, unsigned.
REQ-008 SHALL have port out_valid  output  1: result present on out0/out1.
REQ-009 SHALL have port out_ready  input  1: consumer takes the result this cycle.
REQ-010 SHALL have port out0  output  N: fib(n) mod 2^N, or saturated value when SAT=1.
REQ-011 SHALL have port out1  output  1: overflow flag, high iff the true fib(n) >= 2^N.

Function
REQ-012 SHALL compute fib(0)=0, fib(1)=1, fib(k)=fib(k-1)+fib(k-2); one iteration per clock.
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 Accept: in_valid & in_ready at edge E0.
- Loads a=0, b=1, cnt=n, ov_a=0, ov_b=0.
- Next state DONE if n==0, else RUN.
REQ-015 RUN, each edge:
- (a,b) <= (b, a+b) truncated to N bits.
- ov_a <= ov_b; ov_b <= ov_a | ov_b | carry-out(a+b).
- cnt <= cnt-1.
- Transitions to DONE on the edge where cnt==1.
REQ-016 Latency: out_valid SHALL rise immediately after edge E0+n (n=0: after E0 itself); no other latency is permitted.
REQ-017 in_ready SHALL be 1 in IDLE, 0 in RUN, and equal to out_ready in DONE.
REQ-018 out_valid SHALL be 1 exactly in DONE.
REQ-019 DONE with out_ready=0 SHALL hold state; out0/out1 stable until taken.
REQ-020 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE.
REQ-021 DONE with out_ready=1 and in_valid=1 SHALL retire the result and accept the new request on the same edge (per REQ-014), with no idle bubble.
REQ-022 in0 SHALL be sampled only on the accepting edge; changes during RUN/DONE have no effect.
REQ-023 out0 SHALL be a when SAT=0 or ov_a=0, and all-ones when SAT=1 and ov_a=1; out1 SHALL be ov_a.
REQ-024 Outside DONE, out0/out1 SHALL be 0 (not don't-care).
REQ-025 n = 2^N-1 SHALL run the full count without counter wrap; the result is reported per REQ-023.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, a=0, b=1, cnt=0, ov_a=0, ov_b=0; outputs after that edge are out_valid=0, in_ready=1, out0=0, out1=0.
REQ-027 rst SHALL take priority over every handshake.
- An in-flight computation or an untaken result is discarded.
- No request is accepted on a reset edge.
REQ-028 First request SHALL be accepted on the first edge with rst=0 and in_valid=1.

Verification
REQ-029 N=16, SAT=0: in0=21 with 1-cycle in_valid pulse, out_ready=1 -> out_valid rises after edge E0+21; out0=10946, out1=0; one-cycle pulse, then IDLE.
REQ-030 in0=0 -> out0=0, out1=0 after E0; in0=1 -> out0=1 after E0+1; in0=2 -> out0=1 after E0+2.
REQ-031 Overflow, N=16:
- in0=24 -> out0=46368, out1=0.
- in0=25, SAT=0 -> out0=9489, out1=1.
- in0=25, SAT=1 -> out0=65535, out1=1.
REQ-032 Backpressure: in0=10, out_ready=0 for 5 cycles after out_valid -> out0=55 held stable and in_ready=0 throughout; out_ready=1 -> single transfer, then IDLE.
REQ-033 Back-to-back: in_valid held with in0=5 then 7, out_ready=1 -> results 5 then 13; the second request is accepted on the edge retiring the first.
REQ-034 Reset mid-run: in0=21, rst pulsed at E0+10 -> IDLE, no out_valid; new in0=3 -> out0=2 after its E0+3.

Source files
------------

// File: rtl/fib_seq.sv
// Iterative Fibonacci engine: accepts an index n, performs one addition per
// clock, and reports fib(n) (wrapped or saturated) with a sticky overflow flag.
module fib_seq #(
    parameter int unsigned N   = 16,
    parameter int unsigned SAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in0,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out0,
    output logic         out1
);

    localparam bit SatEn = (SAT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         ov_a_q, ov_a_d;
    logic         ov_b_q, ov_b_d;
    logic [N:0]   sum;
    logic         accept;

    assign sum    = {1'b0, a_q} + {1'b0, b_q};
    assign accept = in_valid & in_ready;

    // Handshake and result decode; results are forced to zero outside DONE.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out0      = '0;
        out1      = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
                out0      = (SatEn && ov_a_q) ? {N{1'b1}} : a_q;
                out1      = ov_a_q;
            end
            default: ;
        endcase
    end

    // Next-state: one Fibonacci step per RUN cycle; a new request may be
    // loaded from IDLE or on the same edge that retires a DONE result.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        ov_a_d  = ov_a_q;
        ov_b_d  = ov_b_q;
        case (state_q)
            IDLE: ;
            RUN: begin
                a_d    = b_q;
                b_d    = sum[N-1:0];
                ov_a_d = ov_b_q;
                ov_b_d = ov_a_q | ov_b_q | sum[N];
                cnt_d  = cnt_q - N'(1);
                if (cnt_q == N'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            a_d     = '0;
            b_d     = N'(1);
            cnt_d   = in0;
            ov_a_d  = 1'b0;
            ov_b_d  = 1'b0;
            state_d = (in0 == '0) ? DONE : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= N'(1);
            cnt_q   <= '0;
            ov_a_q  <= 1'b0;
            ov_b_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            ov_a_q  <= ov_a_d;
            ov_b_q  <= ov_b_d;
        end
    end

endmodule

// File: tb/tb_fib_seq.sv
// Bench for fib_seq: directed scenarios with literal results plus a random
// handshake phase checked every cycle against a latency/result model.
module tb_fib_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in0;
    logic        out_ready;

    logic        in_ready0, out_valid0, out1_0;
    logic [15:0] out0_0;
    logic        in_ready1, out_valid1, out1_1;
    logic [15:0] out0_1;

    logic        in_valid_s, out_ready_s;
    logic [7:0]  in0_s;
    logic        in_ready2, out_valid2, out1_2;
    logic [7:0]  out0_2;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    fib_seq #(.N(16), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in0(in0), .out_valid(out_valid0), .out_ready(out_ready),
        .out0(out0_0), .out1(out1_0)
    );

    fib_seq #(.N(16), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in0(in0), .out_valid(out_valid1), .out_ready(out_ready),
        .out0(out0_1), .out1(out1_1)
    );

    fib_seq #(.N(8), .SAT(1)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready2),
        .in0(in0_s), .out_valid(out_valid2), .out_ready(out_ready_s),
        .out0(out0_2), .out1(out1_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: modular value by plain iteration, overflow from a capped true value.
    function automatic void fib_ref(input int n, input int w,
                                    output longint unsigned modv, output bit ov);
        longint unsigned m = 64'd1 << w;
        longint unsigned cap = 64'd1 << 40;
        longint unsigned ma = 0, mb = 1, ta = 0, tb = 1, t;
        for (int i = 0; i < n; i++) begin
            t  = (ma + mb) % m;
            ma = mb;
            mb = t;
            t  = ta + tb;
            if (t > cap) t = cap;
            ta = tb;
            tb = t;
        end
        modv = ma;
        ov   = (ta >= m);
    endfunction

    // Model: 0 = idle, 1 = computing (m_left edges remaining), 2 = result held.
    int              m_ph = 0;
    int              m_left = 0;
    longint unsigned m_mod = 0;
    bit              m_ov = 1'b0;

    always @(posedge clk) begin
        int              ph;
        int              left;
        bit              rdy;
        longint unsigned mv;
        bit              o;
        ph   = m_ph;
        left = m_left;
        mv   = m_mod;
        o    = m_ov;
        if (rst) begin
            ph = 0;
        end else begin
            rdy = (m_ph == 0) || (m_ph == 2 && out_ready);
            if (m_ph == 1) begin
                left = left - 1;
                if (left == 0) ph = 2;
            end else if (m_ph == 2 && out_ready) begin
                ph = 0;
            end
            if (in_valid && rdy) begin
                left = int'(in0);
                ph   = (in0 == 16'd0) ? 2 : 1;
                fib_ref(int'(in0), 16, mv, o);
            end
        end
        m_ph   <= ph;
        m_left <= left;
        m_mod  <= mv;
        m_ov   <= o;
    end

    // Per-cycle compare of both 16-bit instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_out_valid", out_valid0, (m_ph == 2) ? 1 : 0);
            chk("m_in_ready", in_ready0, (m_ph == 0) ? 1 : (m_ph == 2 ? longint'(out_ready) : 0));
            chk("m_out0", out0_0, (m_ph == 2) ? longint'(m_mod) : 0);
            chk("m_out1", out1_0, (m_ph == 2) ? longint'(m_ov) : 0);
            chk("m_sat_out_valid", out_valid1, (m_ph == 2) ? 1 : 0);
            chk("m_sat_in_ready", in_ready1, (m_ph == 0) ? 1 : (m_ph == 2 ? longint'(out_ready) : 0));
            chk("m_sat_out0", out0_1, (m_ph == 2) ? (m_ov ? 65535 : longint'(m_mod)) : 0);
            chk("m_sat_out1", out1_1, (m_ph == 2) ? longint'(m_ov) : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request with out_ready=1: checks exact latency, result, and single-cycle pulse.
    task automatic run_one(input int n, input longint e0, input longint es, input longint e1);
        int k;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in0       = 16'(n);
        step();
        in_valid = 1'b0;
        in0      = 16'($urandom);
        k = 0;
        while (!out_valid0 && k < n + 5) begin
            step();
            k++;
        end
        chk($sformatf("lat_n%0d", n), k, n);
        chk($sformatf("sat_vld_n%0d", n), out_valid1, 1);
        chk($sformatf("out0_n%0d", n), out0_0, e0);
        chk($sformatf("sat_out0_n%0d", n), out0_1, es);
        chk($sformatf("out1_n%0d", n), out1_0, e1);
        chk($sformatf("sat_out1_n%0d", n), out1_1, e1);
        step();
        chk($sformatf("pulse_n%0d", n), out_valid0, 0);
        chk($sformatf("idle_rdy_n%0d", n), in_ready0, 1);
    endtask

    task automatic run_small(input int n, input longint e0, input longint e1);
        int k;
        out_ready_s = 1'b1;
        in_valid_s  = 1'b1;
        in0_s       = 8'(n);
        step();
        in_valid_s = 1'b0;
        k = 0;
        while (!out_valid2 && k < n + 5) begin
            step();
            k++;
        end
        chk($sformatf("n8_lat_n%0d", n), k, n);
        chk($sformatf("n8_out0_n%0d", n), out0_2, e0);
        chk($sformatf("n8_out1_n%0d", n), out1_2, e1);
        step();
        chk($sformatf("n8_pulse_n%0d", n), out_valid2, 0);
    endtask

    initial begin
        longint unsigned mv;
        bit              o;
        int              k;

        rst = 1'b1; in_valid = 1'b1; in0 = 16'd4; out_ready = 1'b1;
        in_valid_s = 1'b0; in0_s = 8'd0; out_ready_s = 1'b1;

        fib_ref(21, 16, mv, o); chk("ref_fib21", longint'(mv), 10946); chk("ref_ov21", o, 0);
        fib_ref(25, 16, mv, o); chk("ref_fib25", longint'(mv), 9489);  chk("ref_ov25", o, 1);
        fib_ref(24, 16, mv, o); chk("ref_fib24", longint'(mv), 46368); chk("ref_ov24", o, 0);

        // Reset wins over a pending request.
        step();
        chk_en = 1'b1;
        step();
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_out0", out0_0, 0);
        chk("rst_out1", out1_0, 0);
        rst = 1'b0; in_valid = 1'b0;

        run_one(21, 10946, 10946, 0);
        run_one(0, 0, 0, 0);
        run_one(1, 1, 1, 0);
        run_one(2, 1, 1, 0);
        run_one(24, 46368, 46368, 0);
        run_one(25, 9489, 65535, 1);

        // Backpressure holds the result.
        out_ready = 1'b0; in_valid = 1'b1; in0 = 16'd10;
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid0 && k < 15) begin
            step();
            k++;
        end
        chk("bp_lat", k, 10);
        for (int i = 0; i < 5; i++) begin
            in0 = 16'($urandom);
            chk("bp_out0", out0_0, 55);
            chk("bp_in_ready", in_ready0, 0);
            chk("bp_out_valid", out_valid0, 1);
            step();
        end
        out_ready = 1'b1;
        chk("bp_still_valid", out_valid0, 1);
        step();
        chk("bp_taken", out_valid0, 0);
        chk("bp_idle", in_ready0, 1);

        // Back-to-back: second request accepted on the retiring edge.
        out_ready = 1'b1; in_valid = 1'b1; in0 = 16'd5;
        step();
        in0 = 16'd7;
        k = 0;
        while (!out_valid0 && k < 10) begin
            step();
            k++;
        end
        chk("b2b_lat1", k, 5);
        chk("b2b_out0_1", out0_0, 5);
        chk("b2b_ready", in_ready0, 1);
        step();
        in_valid = 1'b0;
        chk("b2b_busy", out_valid0, 0);
        chk("b2b_busy_rdy", in_ready0, 0);
        k = 0;
        while (!out_valid0 && k < 12) begin
            step();
            k++;
        end
        chk("b2b_lat2", k, 7);
        chk("b2b_out0_2", out0_0, 13);
        step();

        // Reset mid-run discards the computation.
        in_valid = 1'b1; in0 = 16'd21;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_out_valid", out_valid0, 0);
        chk("mr_in_ready", in_ready0, 1);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("mr_no_valid", out_valid0, 0);
        end
        run_one(3, 2, 2, 0);

        // Narrow instance: full-count index and the overflow boundary.
        run_small(255, 255, 1);
        run_small(13, 233, 0);
        run_small(14, 255, 1);

        // Random handshakes, checked by the model every cycle.
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in0       = 16'($urandom_range(0, 30));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) step();
        chk("drain_idle", in_ready0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
